// File: rtl/lieat_bjp_pkg.sv
// ============================================================================
// lieat_bjp_pkg : shared op codes and defaults for the branch/jump resolver
// Rev 1.0
// ============================================================================
`default_nettype none

package lieat_bjp_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      BJP_JAL  = 3'd0,
      BJP_JALR = 3'd1,
      BJP_BEQ  = 3'd2,
      BJP_BNE  = 3'd3,
      BJP_BLT  = 3'd4,
      BJP_BGE  = 3'd5,
      BJP_BLTU = 3'd6,
      BJP_BGEU = 3'd7
   } bjp_op_e;

   function automatic logic bjp_is_jump(input bjp_op_e op);
      return (op == BJP_JAL) || (op == BJP_JALR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/lieat_exu_bjp_res_if.sv
// ============================================================================
// lieat_exu_bjp_res_if : op, writeback, redirect and predictor-update bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface lieat_exu_bjp_res_if #(
   parameter int XLEN      = lieat_bjp_pkg::XLEN_DEFAULT,
   parameter int BHT_IDX_W = 5
);
   import lieat_bjp_pkg::*;

   logic                 bjp_valid;
   logic                 bjp_ready;
   bjp_op_e              bjp_op;
   logic [XLEN-1:0]      bjp_pc;
   logic [XLEN-1:0]      bjp_imm;
   logic [XLEN-1:0]      bjp_src1;
   logic [XLEN-1:0]      bjp_src2;
   logic                 bjp_prdt;
   logic [XLEN-1:0]      bjp_prdt_tgt;

   logic                 wb_valid;
   logic                 wb_ready;
   logic [XLEN-1:0]      wb_data;

   logic                 flush_req;
   logic [XLEN-1:0]      flush_pc;

   logic                 upd_valid;
   logic                 upd_ready;
   logic [BHT_IDX_W-1:0] upd_index;
   logic                 upd_taken;

   modport master (
      output bjp_valid, bjp_op, bjp_pc, bjp_imm, bjp_src1, bjp_src2,
             bjp_prdt, bjp_prdt_tgt, wb_ready, upd_ready,
      input  bjp_ready, wb_valid, wb_data, flush_req, flush_pc,
             upd_valid, upd_index, upd_taken
   );

   modport slave (
      input  bjp_valid, bjp_op, bjp_pc, bjp_imm, bjp_src1, bjp_src2,
             bjp_prdt, bjp_prdt_tgt, wb_ready, upd_ready,
      output bjp_ready, wb_valid, wb_data, flush_req, flush_pc,
             upd_valid, upd_index, upd_taken
   );

endinterface

`default_nettype wire

// File: rtl/lieat_bjp_upd_fifo.sv
// ============================================================================
// lieat_bjp_upd_fifo : power-of-two FIFO for branch predictor updates
// Rev 1.0
// ============================================================================
`default_nettype none

module lieat_bjp_upd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] data_o
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Extra MSB on each pointer distinguishes full from empty after wrap.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push_w;
   logic             do_pop_w;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push_w = push_i & ~full_o;
   assign do_pop_w  = pop_i & ~empty_o;
   assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop_w)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_w) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/lieat_exu_bjp_res.sv
// ============================================================================
// lieat_exu_bjp_res : branch/jump resolve, link writeback, redirect, BHT update
// Rev 1.0
// ============================================================================
`default_nettype none

module lieat_exu_bjp_res
   import lieat_bjp_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter int BHT_IDX_W = 5,
   parameter int UPD_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lieat_exu_bjp_res_if.slave   bus,
   input  logic                 flush_sh,
   output logic [CNT_W-1:0]     br_cnt,
   output logic [CNT_W-1:0]     mis_cnt
);

   logic              is_jump_w;
   logic              slt_w, ult_w, eq_w, cond_w;
   logic [XLEN-1:0]   sdiff_lo_w;
   logic [XLEN-1:0]   udiff_unused_w;
   logic [XLEN-1:0]   br_tgt_w, jalr_sum_w, target_w, link_w;
   logic              mispred_w;
   logic              ready_w, accept_w, live_w, push_w;
   logic              q_full_w, q_empty_w;
   logic [BHT_IDX_W:0] q_head_w;

   logic              wb_valid_q, wb_valid_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              flush_req_q, flush_req_d;
   logic [XLEN-1:0]   flush_pc_q, flush_pc_d;
   logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

   assign is_jump_w = bjp_is_jump(bus.bjp_op);

   // Sign-extended subtract cannot overflow, so its MSB is the signed less-than.
   assign {slt_w, sdiff_lo_w} = {bus.bjp_src1[XLEN-1], bus.bjp_src1}
                              - {bus.bjp_src2[XLEN-1], bus.bjp_src2};
   assign {ult_w, udiff_unused_w} = {1'b0, bus.bjp_src1} - {1'b0, bus.bjp_src2};
   assign eq_w = (sdiff_lo_w == '0);

   always_comb begin
      cond_w = 1'b1;
      case (bus.bjp_op)
         BJP_BEQ:  cond_w = eq_w;
         BJP_BNE:  cond_w = ~eq_w;
         BJP_BLT:  cond_w = slt_w;
         BJP_BGE:  cond_w = ~slt_w;
         BJP_BLTU: cond_w = ult_w;
         BJP_BGEU: cond_w = ~ult_w;
         default:  cond_w = 1'b1;
      endcase
   end

   assign br_tgt_w   = bus.bjp_pc + bus.bjp_imm;
   assign jalr_sum_w = bus.bjp_src1 + bus.bjp_imm;
   assign target_w   = (bus.bjp_op == BJP_JALR) ? (jalr_sum_w & ~XLEN'(1)) : br_tgt_w;
   assign link_w     = bus.bjp_pc + XLEN'(4);
   assign mispred_w  = (bus.bjp_prdt != cond_w) ||
                       (cond_w && (bus.bjp_prdt_tgt != target_w));

   // Jumps never touch the update queue, so a full queue only stalls branches.
   assign ready_w  = (~wb_valid_q | bus.wb_ready) & (~q_full_w | is_jump_w);
   assign accept_w = bus.bjp_valid & ready_w;
   assign live_w   = accept_w & ~flush_sh;
   assign push_w   = live_w & ~is_jump_w;

   lieat_bjp_upd_fifo #(
      .DEPTH (UPD_DEPTH),
      .WIDTH (BHT_IDX_W + 1)
   ) u_upd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_w),
      .data_i  ({bus.bjp_pc[BHT_IDX_W+1:2], cond_w}),
      .pop_i   (bus.upd_ready),
      .full_o  (q_full_w),
      .empty_o (q_empty_w),
      .data_o  (q_head_w)
   );

   always_comb begin
      wb_valid_d = wb_valid_q;
      if (bus.wb_ready)          wb_valid_d = 1'b0;
      if (live_w && is_jump_w)   wb_valid_d = 1'b1;
      if (flush_sh)              wb_valid_d = 1'b0;
      wb_data_d   = (live_w && is_jump_w) ? link_w : wb_data_q;
      flush_req_d = live_w & mispred_w;
      flush_pc_d  = flush_req_d ? (cond_w ? target_w : link_w) : flush_pc_q;
      br_cnt_d    = br_cnt_q;
      mis_cnt_d   = mis_cnt_q;
      if (push_w && (br_cnt_q != '1))       br_cnt_d  = br_cnt_q + CNT_W'(1);
      if (flush_req_d && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         flush_req_q <= 1'b0;
         flush_pc_q  <= '0;
         br_cnt_q    <= '0;
         mis_cnt_q   <= '0;
      end else begin
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         flush_req_q <= flush_req_d;
         flush_pc_q  <= flush_pc_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
      end
   end

   assign bus.bjp_ready = ready_w;
   assign bus.wb_valid  = wb_valid_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.flush_req = flush_req_q;
   assign bus.flush_pc  = flush_pc_q;
   assign bus.upd_valid = ~q_empty_w;
   assign {bus.upd_index, bus.upd_taken} = q_head_w;
   assign br_cnt  = br_cnt_q;
   assign mis_cnt = mis_cnt_q;

endmodule

`default_nettype wire
